map_ss_seq: RTL and testbench

MAP_SS_SEQ -- requirements
Module: map_ss_seq

---
 rtl/map_ss_seq.sv | 133 +++++++++++++
 tb/tb_map_ss_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/map_ss_seq.sv
// Walks all save-state addresses once, either copying mapper state into the buffer or restoring it back.
// Every address is held for HOLD cycles so the mapper's m2-domain registers see stable address and data.
module map_ss_seq #(
    parameter int SS_LEN  = 128,
    parameter int HOLD    = 4,
    parameter int RO_ADDR = 127
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       start,
    input  logic       dir,
    output logic       busy,
    output logic       done,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [6:0] buf_addr,
    output logic       buf_wr,
    output logic       buf_rd,
    output logic [7:0] buf_wdat,
    input  logic [7:0] buf_rdat
);

    localparam logic [6:0] LAST    = 7'(SS_LEN - 1);
    localparam logic [6:0] RO      = 7'(RO_ADDR);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    typedef enum logic [2:0] {
        IDLE, S_ADDR, S_WAIT, S_CAP, R_RD, R_WE, R_GAP, FIN
    } state_t;

    state_t     state, nxt;
    logic [6:0] idx, idx_nxt;
    logic       dir_q, dir_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] wdat_q, wdat_nxt;
    logic       step;

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state  <= IDLE;
            idx    <= '0;
            dir_q  <= 1'b0;
            cnt    <= '0;
            wdat_q <= '0;
        end else begin
            state  <= nxt;
            idx    <= idx_nxt;
            dir_q  <= dir_nxt;
            cnt    <= cnt_nxt;
            wdat_q <= wdat_nxt;
        end
    end

    always_comb begin
        nxt      = state;
        idx_nxt  = idx;
        dir_nxt  = dir_q;
        cnt_nxt  = cnt;
        wdat_nxt = wdat_q;
        step     = 1'b0;
        busy     = (state != IDLE);
        ss_act   = (state != IDLE);
        done     = 1'b0;
        ss_we    = 1'b0;
        buf_wr   = 1'b0;
        buf_rd   = 1'b0;
        buf_wdat = '0;
        ss_wdat  = wdat_q;
        ss_addr  = (state == IDLE) ? 8'h00 : {1'b0, idx};
        buf_addr = idx;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt = '0;
                    dir_nxt = dir;
                    nxt     = dir ? R_RD : S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_nxt = '0;
                nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == HOLD_M1) nxt = S_CAP;
                else                cnt_nxt = cnt + 4'd1;
            end
            S_CAP: begin
                buf_wr   = 1'b1;
                buf_wdat = ss_rdat;
                step     = 1'b1;
            end
            R_RD: begin
                cnt_nxt = '0;
                if (idx == RO) begin
                    step = 1'b1;
                end else begin
                    buf_rd = 1'b1;
                    nxt    = R_WE;
                end
            end
            R_WE: begin
                ss_we = 1'b1;
                // buffer data arrives on the first R_WE cycle; capture it there and hold for the burst
                if (cnt == '0) begin
                    ss_wdat  = buf_rdat;
                    wdat_nxt = buf_rdat;
                end
                if (cnt == HOLD_M1) nxt = R_GAP;
                else                cnt_nxt = cnt + 4'd1;
            end
            R_GAP: step = 1'b1;
            FIN: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase

        if (step) begin
            if (idx == LAST) begin
                nxt = FIN;
            end else begin
                idx_nxt = idx + 7'd1;
                nxt     = dir_q ? R_RD : S_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq: full save/restore walks against buffer and mapper models, plus abort and short-config cases.
module tb_map_ss_seq;

    logic       clk = 1'b0;
    logic       map_rst, start, dir, start1;
    logic       busy, done, ss_act, ss_we, buf_wr, buf_rd;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, buf_wdat, buf_rdat;
    logic [6:0] buf_addr;
    logic       busy1, done1, ss_act1, ss_we1, buf_wr1, buf_rd1;
    logic [7:0] ss_addr1, ss_wdat1, ss_rdat1, buf_wdat1;
    logic [6:0] buf_addr1;

    always #5 clk = ~clk;

    map_ss_seq u_dut (
        .clk(clk), .map_rst(map_rst), .start(start), .dir(dir),
        .busy(busy), .done(done), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_rd(buf_rd),
        .buf_wdat(buf_wdat), .buf_rdat(buf_rdat)
    );

    map_ss_seq #(.SS_LEN(1), .HOLD(1), .RO_ADDR(127)) u_short (
        .clk(clk), .map_rst(map_rst), .start(start1), .dir(1'b0),
        .busy(busy1), .done(done1), .ss_act(ss_act1), .ss_we(ss_we1),
        .ss_addr(ss_addr1), .ss_wdat(ss_wdat1), .ss_rdat(ss_rdat1),
        .buf_addr(buf_addr1), .buf_wr(buf_wr1), .buf_rd(buf_rd1),
        .buf_wdat(buf_wdat1), .buf_rdat(8'h00)
    );

    assign ss_rdat  = ss_addr ^ 8'h5A;
    assign ss_rdat1 = ss_addr1 ^ 8'h5A;

    logic [7:0] mem [128];
    logic [7:0] mreg [256];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (buf_wr) mem[buf_addr] <= buf_wdat;
        if (buf_rd) buf_rdat <= mem[buf_addr];
        if (ss_we)  mreg[ss_addr] <= ss_wdat;
    end

    int total = 0, bad = 0;
    int excl_err, addr_err, dat_err, burst_err, we_cyc, we_ro, burst_n, wr_n, rd_n, done_n, t17, t19, run_len;
    logic       prev_we = 1'b0;
    logic [7:0] prev_addr = '0;

    task automatic clear_mon();
        excl_err = 0; addr_err = 0; dat_err = 0; burst_err = 0; we_cyc = 0; we_ro = 0;
        burst_n = 0; wr_n = 0; rd_n = 0; done_n = 0; t17 = -1; t19 = -1; run_len = 0;
    endtask

    always @(negedge clk) begin
        if (int'(ss_we) + int'(buf_wr) + int'(buf_rd) > 1) excl_err++;
        if (ss_we && prev_we && ss_addr != prev_addr) addr_err++;
        if (ss_we) begin
            we_cyc++;
            run_len++;
            if (!prev_we) burst_n++;
            if (ss_addr == 8'd127) we_ro++;
            if (ss_wdat != ~ss_addr) dat_err++;
            if (ss_addr == 8'd17 && t17 < 0) t17 = cyc;
            if (ss_addr == 8'd19 && t19 < 0) t19 = cyc;
        end else if (prev_we) begin
            if (run_len != 4) burst_err++;
            run_len = 0;
        end
        if (buf_wr) wr_n++;
        if (buf_rd) rd_n++;
        if (done) done_n++;
        prev_we   = ss_we;
        prev_addr = ss_addr;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulses start at a negedge, returns the cycle (start cycle = 0) at which done is seen, or -1.
    task automatic run(input logic d, input bit restarts, output int dcyc);
        int t0;
        @(negedge clk);
        start = 1'b1; dir = d; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                dcyc = cyc - t0;
                break;
            end
            if (restarts && (cyc - t0 == 3 || cyc - t0 == 50)) begin
                start = 1'b1; dir = ~d;
            end else begin
                start = 1'b0; dir = d;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int dc, errs, k;

    initial begin
        map_rst = 1'b1; start = 1'b0; dir = 1'b0; start1 = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_act", ss_act, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {ss_we, buf_wr, buf_rd}, 0);
        check("rst_addr", ss_addr, 0);
        check("rst_wdat", {ss_wdat, buf_wdat}, 0);
        map_rst = 1'b0;

        // save with start re-pulsed mid-run
        @(posedge clk); clear_mon();
        run(1'b0, 1'b1, dc);
        check("save_done_cyc", dc, 769);
        @(negedge clk);
        check("save_busy_after", busy, 0);
        check("save_act_after", ss_act, 0);
        check("save_done_n", done_n, 1);
        check("save_wr_n", wr_n, 128);
        check("save_rd_n", rd_n, 0);
        check("save_we_cyc", we_cyc, 0);
        errs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] != (8'(i) ^ 8'h5A)) errs++;
        check("save_mem", errs, 0);
        check("save_excl", excl_err, 0);

        // restore from buffer[i] = ~i
        for (int i = 0; i < 128; i++) mem[i] <= ~8'(i);
        for (int i = 0; i < 256; i++) mreg[i] <= 8'h00;
        @(posedge clk); clear_mon();
        run(1'b1, 1'b0, dc);
        check("rest_done_cyc", dc, 764);
        @(negedge clk);
        check("rest_bursts", burst_n, 127);
        check("rest_we_cyc", we_cyc, 508);
        check("rest_burst_len", burst_err, 0);
        check("rest_we_ro", we_ro, 0);
        check("rest_rd_n", rd_n, 127);
        check("rest_data_held", dat_err, 0);
        check("rest_addr_stable", addr_err, 0);
        check("rest_17_before_19", int'(t17 >= 0 && t19 > t17), 1);
        errs = 0;
        for (int i = 0; i < 127; i++) if (mreg[i] != ~8'(i)) errs++;
        check("rest_mreg", errs, 0);
        check("rest_mreg_ro", mreg[127], 0);
        check("rest_excl", excl_err, 0);

        // abort during the R_WE burst of idx 10
        @(negedge clk);
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(ss_we && ss_addr == 8'd10) && k < 500) begin
            @(negedge clk); k++;
        end
        check("abort_reached", int'(ss_we && ss_addr == 8'd10), 1);
        map_rst = 1'b1;
        @(negedge clk);
        check("abort_we", ss_we, 0);
        check("abort_act", ss_act, 0);
        check("abort_busy", busy, 0);
        map_rst = 1'b0;
        @(posedge clk); clear_mon();
        repeat (20) @(negedge clk);
        check("abort_done_n", done_n, 0);
        check("abort_access", rd_n + wr_n + we_cyc, 0);
        @(posedge clk); clear_mon();
        run(1'b0, 1'b0, dc);
        check("after_abort_done", dc, 769);
        @(negedge clk);
        errs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] != (8'(i) ^ 8'h5A)) errs++;
        check("after_abort_mem", errs, 0);

        // start together with reset in IDLE
        @(negedge clk);
        map_rst = 1'b1; start = 1'b1; dir = 1'b0;
        @(negedge clk);
        map_rst = 1'b0; start = 1'b0;
        check("rst_start_busy0", busy, 0);
        @(negedge clk);
        check("rst_start_busy1", busy, 0);
        check("rst_start_addr", ss_addr, 0);

        // HOLD=1, SS_LEN=1 instance: S_ADDR, S_WAIT, S_CAP, FIN, IDLE
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("short_c1_busy", {busy1, ss_act1, buf_wr1, done1}, 4'b1100);
        @(negedge clk);
        check("short_c2", {busy1, buf_wr1, done1}, 3'b100);
        @(negedge clk);
        check("short_c3_wr", {busy1, buf_wr1, done1}, 3'b110);
        check("short_c3_dat", buf_wdat1, 8'h5A);
        @(negedge clk);
        check("short_c4_done", {busy1, ss_act1, done1}, 3'b111);
        @(negedge clk);
        check("short_c5_idle", {busy1, ss_act1, done1}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
